// File: rtl/color_sort_sequencer.sv
// color_sort_sequencer
// Debounces the color sensor's det/led_st flags, issues one sort request per
// object to the arm (req/ack/done), then pulses clr_led to re-arm the sensor.
// A request that sees no completion within TIMEOUT_CYCLES latches fault until
// reset.
//
// Optional feature macro: COLOR_SORT_TALLY_EN adds per-color completion
// counters (red_cnt, green_cnt, blue_cnt) that saturate at 2**CNT_W-1.
//
// Ports:
//   clk_sort_50       system clock (50 MHz)
//   rst               asynchronous active-high reset
//   det, led_st[2:0]  sensor detect flag and one-hot color (b0 blue, b1 green, b2 red)
//   pick_req          sort request to the arm, held until pick_ack
//   pick_color[1:0]   color code: 0 none, 1 red, 2 green, 3 blue
//   pick_ack          arm accepted the request
//   pick_done         arm finished placing the object
//   clr_led           re-arm pulse to the sensor, held until det drops
//   busy              high in every state except IDLE
//   fault             timeout latched
//   red/green/blue_cnt  completed picks per color (COLOR_SORT_TALLY_EN only)
module color_sort_sequencer #(
    parameter int unsigned STABLE_CYCLES  = 50000,
    parameter int unsigned TIMEOUT_CYCLES = 500000000,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clk_sort_50,
    input  logic             rst,
    input  logic             det,
    input  logic [2:0]       led_st,
    output logic             pick_req,
    output logic [1:0]       pick_color,
    input  logic             pick_ack,
    input  logic             pick_done,
    output logic             clr_led,
    output logic             busy,
    output logic             fault
`ifdef COLOR_SORT_TALLY_EN
    ,
    output logic [CNT_W-1:0] red_cnt,
    output logic [CNT_W-1:0] green_cnt,
    output logic [CNT_W-1:0] blue_cnt
`endif
);

    localparam int unsigned STAB_W = 32;
    localparam int unsigned TMR_W  = 32;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUALIFY,
        S_REQUEST,
        S_WAIT_DONE,
        S_CLEAR,
        S_FAULT
    } state_e;

    state_e              state_q, state_d;
    logic                det_s1_q, det_s2_q;
    logic [2:0]          led_s1_q, led_s2_q;
    logic [STAB_W-1:0]   stab_q, stab_d;
    logic [TMR_W-1:0]    timer_q, timer_d, timer_inc_c;
    logic [1:0]          color_q, color_d;
    logic [1:0]          sample_code_c;
    logic                pick_req_q, pick_req_d;
    logic [1:0]          pick_color_q, pick_color_d;
    logic                clr_led_q, clr_led_d;
    logic                busy_q, busy_d;
    logic                fault_q, fault_d;

    // Synchronized color pattern to code; anything not exactly one-hot is "none".
    always_comb begin
        sample_code_c = 2'd0;
        case (led_s2_q)
            3'b100:  sample_code_c = 2'd1;
            3'b010:  sample_code_c = 2'd2;
            3'b001:  sample_code_c = 2'd3;
            default: sample_code_c = 2'd0;
        endcase
    end

    // Next-state logic; outputs are derived from the next state so they
    // change on the same edge as the state they describe.
    always_comb begin
        state_d     = state_q;
        stab_d      = stab_q;
        timer_d     = timer_q;
        color_d     = color_q;
        timer_inc_c = timer_q + TMR_W'(1);

        case (state_q)
            S_IDLE: begin
                if (det_s2_q && (sample_code_c != 2'd0)) begin
                    color_d = sample_code_c;
                    stab_d  = STAB_W'(1);
                    state_d = S_QUALIFY;
                end
            end
            S_QUALIFY: begin
                if (det_s2_q && (sample_code_c == color_q)) begin
                    if (stab_q == STAB_LAST) begin
                        stab_d  = '0;
                        timer_d = '0;
                        state_d = S_REQUEST;
                    end else begin
                        stab_d = stab_q + STAB_W'(1);
                    end
                end else begin
                    stab_d  = '0;
                    state_d = S_IDLE;
                end
            end
            S_REQUEST: begin
                timer_d = timer_inc_c;
                // A completion on the timeout cycle wins over the fault.
                if (pick_ack && pick_done) begin
                    state_d = S_CLEAR;
                end else if (timer_inc_c == TMR_LIMIT) begin
                    state_d = S_FAULT;
                end else if (pick_ack) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                timer_d = timer_inc_c;
                if (pick_done) begin
                    state_d = S_CLEAR;
                end else if (timer_inc_c == TMR_LIMIT) begin
                    state_d = S_FAULT;
                end
            end
            S_CLEAR: begin
                if (!det_s2_q) begin
                    state_d = S_IDLE;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pick_req_d   = (state_d == S_REQUEST);
        pick_color_d = ((state_d == S_REQUEST) || (state_d == S_WAIT_DONE)) ? color_d : 2'd0;
        clr_led_d    = (state_d == S_CLEAR);
        busy_d       = (state_d != S_IDLE);
        fault_d      = (state_d == S_FAULT);
    end

    // State, synchronizers and registered outputs.
    always_ff @(posedge clk_sort_50 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            det_s1_q     <= 1'b0;
            det_s2_q     <= 1'b0;
            led_s1_q     <= 3'b000;
            led_s2_q     <= 3'b000;
            stab_q       <= '0;
            timer_q      <= '0;
            color_q      <= 2'd0;
            pick_req_q   <= 1'b0;
            pick_color_q <= 2'd0;
            clr_led_q    <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            det_s1_q     <= det;
            det_s2_q     <= det_s1_q;
            led_s1_q     <= led_st;
            led_s2_q     <= led_s1_q;
            stab_q       <= stab_d;
            timer_q      <= timer_d;
            color_q      <= color_d;
            pick_req_q   <= pick_req_d;
            pick_color_q <= pick_color_d;
            clr_led_q    <= clr_led_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign pick_req   = pick_req_q;
    assign pick_color = pick_color_q;
    assign clr_led    = clr_led_q;
    assign busy       = busy_q;
    assign fault      = fault_q;

`ifdef COLOR_SORT_TALLY_EN
    logic [CNT_W-1:0] red_cnt_q, red_cnt_d;
    logic [CNT_W-1:0] green_cnt_q, green_cnt_d;
    logic [CNT_W-1:0] blue_cnt_q, blue_cnt_d;
    logic             enter_clear_c;

    // Count a completed pick on the edge that enters CLEAR; saturate at all-ones.
    always_comb begin
        red_cnt_d     = red_cnt_q;
        green_cnt_d   = green_cnt_q;
        blue_cnt_d    = blue_cnt_q;
        enter_clear_c = (state_d == S_CLEAR) && (state_q != S_CLEAR);
        if (enter_clear_c) begin
            case (color_q)
                2'd1: if (red_cnt_q != '1) red_cnt_d = red_cnt_q + CNT_W'(1);
                2'd2: if (green_cnt_q != '1) green_cnt_d = green_cnt_q + CNT_W'(1);
                2'd3: if (blue_cnt_q != '1) blue_cnt_d = blue_cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sort_50 or posedge rst) begin
        if (rst) begin
            red_cnt_q   <= '0;
            green_cnt_q <= '0;
            blue_cnt_q  <= '0;
        end else begin
            red_cnt_q   <= red_cnt_d;
            green_cnt_q <= green_cnt_d;
            blue_cnt_q  <= blue_cnt_d;
        end
    end

    assign red_cnt   = red_cnt_q;
    assign green_cnt = green_cnt_q;
    assign blue_cnt  = blue_cnt_q;
`endif

endmodule

// File: tb/tb_color_sort_sequencer.sv
// Testbench for color_sort_sequencer: directed scenarios plus randomized
// objects checked against a transaction-level model of the sort flow.
module tb_color_sort_sequencer;

    localparam int unsigned STABLE  = 4;
    localparam int unsigned TIMEOUT = 20;
    localparam int unsigned CW      = 8;
    localparam int          CMAX    = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       det;
    logic [2:0] led_st;
    logic       pick_req;
    logic [1:0] pick_color;
    logic       pick_ack;
    logic       pick_done;
    logic       clr_led;
    logic       busy;
    logic       fault;
`ifdef COLOR_SORT_TALLY_EN
    logic [CW-1:0] red_cnt, green_cnt, blue_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = -1;
    int m_cnt[4];   // model tallies indexed by color code (1 red, 2 green, 3 blue)

    color_sort_sequencer #(
        .STABLE_CYCLES (STABLE),
        .TIMEOUT_CYCLES(TIMEOUT),
        .CNT_W         (CW)
    ) dut (
        .clk_sort_50(clk),
        .rst        (rst),
        .det        (det),
        .led_st     (led_st),
        .pick_req   (pick_req),
        .pick_color (pick_color),
        .pick_ack   (pick_ack),
        .pick_done  (pick_done),
        .clr_led    (clr_led),
        .busy       (busy),
        .fault      (fault)
`ifdef COLOR_SORT_TALLY_EN
        ,
        .red_cnt    (red_cnt),
        .green_cnt  (green_cnt),
        .blue_cnt   (blue_cnt)
`endif
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Color code the arm should see for a sensor pattern.
    function automatic logic [1:0] code_of(input logic [2:0] p);
        if (p == 3'b100) return 2'd1;
        if (p == 3'b010) return 2'd2;
        if (p == 3'b001) return 2'd3;
        return 2'd0;
    endfunction

    function automatic void model_pick(input logic [1:0] c);
        if (c != 2'd0 && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endfunction

    task automatic go_idle(output bit ok);
        det = 1'b0; pick_ack = 1'b0; pick_done = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b0 && i >= 3) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pick_req === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; det = 1'b1; led_st = 3'b100; pick_ack = 1'b0; pick_done = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (pick_req !== 1'b0) begin errors++; $display("FAIL rst_pick_req: got %b expected 0", pick_req); end
        checks++; if (pick_color !== 2'd0) begin errors++; $display("FAIL rst_pick_color: got %0d expected 0", pick_color); end
        checks++; if (clr_led !== 1'b0) begin errors++; $display("FAIL rst_clr_led: got %b expected 0", clr_led); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fault); end
`ifdef COLOR_SORT_TALLY_EN
        checks++; if ({red_cnt, green_cnt, blue_cnt} !== '0) begin errors++; $display("FAIL rst_tally: got %0d/%0d/%0d expected 0/0/0", red_cnt, green_cnt, blue_cnt); end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Red held from edge 0 (reset spans edges 0 and 1): request after edge STABLE+3.
    task automatic test_latency();
        int n;
        while (cyc < int'(STABLE) + 2) @(negedge clk);
        checks++; if (pick_req !== 1'b0) begin errors++; $display("FAIL lat_early: got %b expected 0 at edge %0d", pick_req, cyc); end
        @(negedge clk);
        checks++; if (pick_req !== 1'b1) begin errors++; $display("FAIL lat_req: got %b expected 1 at edge %0d", pick_req, cyc); end
        checks++; if (pick_color !== 2'd1) begin errors++; $display("FAIL lat_color: got %0d expected 1", pick_color); end
        while (cyc < 9) @(negedge clk);
        checks++; if (pick_req !== 1'b1) begin errors++; $display("FAIL lat_hold: got %b expected 1", pick_req); end
        pick_ack = 1'b1;
        @(negedge clk);
        pick_ack = 1'b0;
        checks++; if (pick_req !== 1'b0) begin errors++; $display("FAIL lat_req_fall: got %b expected 0", pick_req); end
        checks++; if (pick_color !== 2'd1) begin errors++; $display("FAIL lat_color_held: got %0d expected 1", pick_color); end
        while (cyc < 13) @(negedge clk);
        pick_done = 1'b1;
        @(negedge clk);
        pick_done = 1'b0;
        model_pick(2'd1);
        checks++; if (clr_led !== 1'b1) begin errors++; $display("FAIL lat_clr: got %b expected 1", clr_led); end
`ifdef COLOR_SORT_TALLY_EN
        checks++; if (red_cnt !== CW'(m_cnt[1])) begin errors++; $display("FAIL lat_red_cnt: got %0d expected %0d", red_cnt, m_cnt[1]); end
`endif
        repeat (2) @(negedge clk);
        checks++; if (clr_led !== 1'b1) begin errors++; $display("FAIL lat_clr_hold: got %b expected 1", clr_led); end
        det = 1'b0;
        n = 0;
        while (clr_led === 1'b1 && n < 8) begin @(negedge clk); n++; end
        checks++; if (n < 2 || n > 3) begin errors++; $display("FAIL lat_clr_fall: got %0d cycles expected 2..3", n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy: got %b expected 0", busy); end
    endtask

    // Blue for too short, then green: only green is requested.
    task automatic test_requalify();
        bit ok;
        int n;
        go_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rq_idle: busy=%b expected 0", busy); end
        det = 1'b1; led_st = 3'b001;
        repeat (3) @(negedge clk);
        led_st = 3'b010;
        n = 0;
        while (pick_req !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++; if (pick_color !== 2'd2) begin errors++; $display("FAIL rq_color: got %0d expected 2", pick_color); end
        checks++; if (n < int'(STABLE) + 2 || n > int'(STABLE) + 3) begin errors++; $display("FAIL rq_latency: got %0d cycles expected %0d..%0d", n, STABLE + 2, STABLE + 3); end
        pick_ack = 1'b1; pick_done = 1'b1;
        @(negedge clk);
        pick_ack = 1'b0; pick_done = 1'b0;
        model_pick(2'd2);
        checks++; if (clr_led !== 1'b1) begin errors++; $display("FAIL rq_clr: got %b expected 1", clr_led); end
`ifdef COLOR_SORT_TALLY_EN
        checks++; if (green_cnt !== CW'(m_cnt[2])) begin errors++; $display("FAIL rq_green_cnt: got %0d expected %0d", green_cnt, m_cnt[2]); end
`endif
        det = 1'b0;
    endtask

    // Non-one-hot patterns never leave IDLE.
    task automatic test_invalid();
        bit ok;
        int bad;
        logic [2:0] pats [5];
        pats[0] = 3'b011; pats[1] = 3'b000; pats[2] = 3'b111; pats[3] = 3'b110; pats[4] = 3'b101;
        go_idle(ok);
        bad = 0;
        det = 1'b1;
        for (int p = 0; p < 5; p++) begin
            led_st = pats[p];
            repeat ((p == 0) ? 50 : 10) begin
                @(negedge clk);
                if (pick_req !== 1'b0 || busy !== 1'b0) bad++;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL inv_idle: got %0d active cycles expected 0", bad); end
        det = 1'b0;
    endtask

    // Unanswered blue request times out; fault is sticky until reset.
    task automatic test_fault();
        bit ok;
        int k;
        go_idle(ok);
        det = 1'b1; led_st = 3'b001;
        wait_req(ok);
        checks++; if (!ok) begin errors++; $display("FAIL flt_req: pick_req=%b expected 1", pick_req); end
        checks++; if (pick_color !== 2'd3) begin errors++; $display("FAIL flt_color: got %0d expected 3", pick_color); end
        k = 0;
        while (fault !== 1'b1 && k < 40) begin @(negedge clk); k++; end
        checks++; if (k != int'(TIMEOUT)) begin errors++; $display("FAIL flt_timeout: got %0d cycles expected %0d", k, TIMEOUT); end
        checks++; if (pick_req !== 1'b0 || clr_led !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL flt_outputs: got req=%b clr=%b busy=%b expected 0/0/1", pick_req, clr_led, busy); end
        det = 1'b0; pick_ack = 1'b1; pick_done = 1'b1;
        repeat (5) @(negedge clk);
        pick_ack = 1'b0; pick_done = 1'b0; det = 1'b1; led_st = 3'b100;
        repeat (10) @(negedge clk);
        checks++; if (fault !== 1'b1 || pick_req !== 1'b0 || clr_led !== 1'b0) begin errors++; $display("FAIL flt_sticky: got fault=%b req=%b clr=%b expected 1/0/0", fault, pick_req, clr_led); end
`ifdef COLOR_SORT_TALLY_EN
        checks++; if (blue_cnt !== CW'(m_cnt[3])) begin errors++; $display("FAIL flt_blue_cnt: got %0d expected %0d", blue_cnt, m_cnt[3]); end
`endif
        #3 rst = 1'b1;
        #1;
        model_reset();
        checks++; if (fault !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flt_rst: got fault=%b busy=%b expected 0/0", fault, busy); end
        @(negedge clk);
        rst = 1'b0; det = 1'b0;
    endtask

    // Ack and done together skip WAIT_DONE.
    task automatic test_same_cycle();
        bit ok;
        go_idle(ok);
        det = 1'b1; led_st = 3'b001;
        wait_req(ok);
        checks++; if (!ok || pick_color !== 2'd3) begin errors++; $display("FAIL sc_req: got req=%b color=%0d expected 1/3", pick_req, pick_color); end
        pick_ack = 1'b1; pick_done = 1'b1;
        @(negedge clk);
        pick_ack = 1'b0; pick_done = 1'b0;
        model_pick(2'd3);
        checks++; if (clr_led !== 1'b1 || pick_req !== 1'b0) begin errors++; $display("FAIL sc_clear: got clr=%b req=%b expected 1/0", clr_led, pick_req); end
`ifdef COLOR_SORT_TALLY_EN
        checks++; if (blue_cnt !== CW'(m_cnt[3])) begin errors++; $display("FAIL sc_blue_cnt: got %0d expected %0d", blue_cnt, m_cnt[3]); end
`endif
        det = 1'b0;
    endtask

    // Random objects: a request appears iff the pattern is one-hot and det
    // was held for at least STABLE synchronized samples.
    task automatic test_random();
        bit ok, same, seen, exp_req;
        logic [2:0] p;
        logic [1:0] exp_code;
        int l, a, d;
        for (int it = 0; it < 40; it++) begin
            go_idle(ok);
            p        = 3'($urandom_range(0, 7));
            l        = int'($urandom_range(1, 7));
            a        = int'($urandom_range(0, 3));
            d        = int'($urandom_range(0, 3));
            same     = 1'($urandom_range(0, 1));
            exp_code = code_of(p);
            exp_req  = (exp_code != 2'd0) && (l >= int'(STABLE));
            det = 1'b1; led_st = p; seen = 1'b0;
            for (int i = 0; i < l + 6; i++) begin
                if (i == l) det = 1'b0;
                @(negedge clk);
                if (pick_req === 1'b1) begin seen = 1'b1; break; end
            end
            checks++; if (seen !== exp_req) begin errors++; $display("FAIL rnd_req it%0d: got %b expected %b (p=%b l=%0d)", it, seen, exp_req, p, l); end
            if (seen) begin
                checks++; if (pick_color !== exp_code) begin errors++; $display("FAIL rnd_color it%0d: got %0d expected %0d", it, pick_color, exp_code); end
                repeat (a) @(negedge clk);
                pick_ack = 1'b1; pick_done = same;
                @(negedge clk);
                pick_ack = 1'b0; pick_done = 1'b0;
                if (!same) begin
                    checks++; if (pick_req !== 1'b0 || pick_color !== exp_code) begin errors++; $display("FAIL rnd_wait it%0d: got req=%b color=%0d expected 0/%0d", it, pick_req, pick_color, exp_code); end
                    repeat (d) @(negedge clk);
                    pick_done = 1'b1;
                    @(negedge clk);
                    pick_done = 1'b0;
                end
                model_pick(exp_code);
                checks++; if (clr_led !== 1'b1) begin errors++; $display("FAIL rnd_clr it%0d: got %b expected 1", it, clr_led); end
`ifdef COLOR_SORT_TALLY_EN
                checks++; if (red_cnt !== CW'(m_cnt[1]) || green_cnt !== CW'(m_cnt[2]) || blue_cnt !== CW'(m_cnt[3])) begin errors++; $display("FAIL rnd_tally it%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", it, red_cnt, green_cnt, blue_cnt, m_cnt[1], m_cnt[2], m_cnt[3]); end
`endif
            end
            det = 1'b0;
        end
        go_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rnd_idle: busy=%b expected 0", busy); end
    endtask

`ifdef COLOR_SORT_TALLY_EN
    // Blue tally saturates at all-ones.
    task automatic test_saturate();
        bit ok;
        int bad, n;
        bad = 0; n = 0;
        while ((m_cnt[3] < CMAX || n == 0) && bad < 5) begin
            if (m_cnt[3] == CMAX) n = 1;
            go_idle(ok);
            det = 1'b1; led_st = 3'b001;
            wait_req(ok);
            if (!ok) bad++;
            pick_ack = 1'b1; pick_done = 1'b1;
            @(negedge clk);
            pick_ack = 1'b0; pick_done = 1'b0; det = 1'b0;
            model_pick(2'd3);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL sat_req: got %0d missing requests expected 0", bad); end
        checks++; if (blue_cnt !== CW'(CMAX)) begin errors++; $display("FAIL sat_blue: got %0d expected %0d", blue_cnt, CMAX); end
        checks++; if (red_cnt !== CW'(m_cnt[1]) || green_cnt !== CW'(m_cnt[2])) begin errors++; $display("FAIL sat_others: got %0d/%0d expected %0d/%0d", red_cnt, green_cnt, m_cnt[1], m_cnt[2]); end
    endtask
`endif

    // Reset mid-handshake (REQUEST, WAIT_DONE, CLEAR) clears outputs without a clock edge.
    task automatic test_rst_async();
        bit ok;
        for (int ph = 0; ph < 3; ph++) begin
            go_idle(ok);
            det = 1'b1; led_st = 3'b100;
            wait_req(ok);
            if (ph >= 1) begin
                pick_ack = 1'b1; pick_done = (ph == 2);
                @(negedge clk);
                pick_ack = 1'b0; pick_done = 1'b0;
                if (ph == 2) model_pick(2'd1);
            end
            checks++; if ({pick_req, clr_led, busy} !== ((ph == 0) ? 3'b101 : (ph == 1) ? 3'b001 : 3'b011)) begin errors++; $display("FAIL ar_pre ph%0d: got req/clr/busy=%b%b%b", ph, pick_req, clr_led, busy); end
            #3 rst = 1'b1;
            #1;
            model_reset();
            checks++; if (pick_req !== 1'b0 || clr_led !== 1'b0 || busy !== 1'b0 || fault !== 1'b0 || pick_color !== 2'd0) begin errors++; $display("FAIL ar_out ph%0d: got req=%b clr=%b busy=%b fault=%b color=%0d expected all 0", ph, pick_req, clr_led, busy, fault, pick_color); end
`ifdef COLOR_SORT_TALLY_EN
            checks++; if ({red_cnt, green_cnt, blue_cnt} !== '0) begin errors++; $display("FAIL ar_tally ph%0d: got %0d/%0d/%0d expected 0", ph, red_cnt, green_cnt, blue_cnt); end
`endif
            @(negedge clk);
            rst = 1'b0; det = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_requalify();
        test_invalid();
        test_fault();
        test_same_cycle();
        test_random();
`ifdef COLOR_SORT_TALLY_EN
        test_saturate();
`endif
        test_rst_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
